// File: rtl/csr_rmw_seq_pkg.sv
// Shared definitions for the CSR read-modify-write sequencer:
// op encodings, logic-unit select codes and the FSM state type.
package csr_rmw_seq_pkg;

    localparam logic [1:0] OP_RW   = 2'b00;
    localparam logic [1:0] OP_RS   = 2'b01;
    localparam logic [1:0] OP_RC   = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [7:0] SEL_OR  = 8'h02;
    localparam logic [7:0] SEL_SET = 8'h40;
    localparam logic [7:0] SEL_CLR = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_RESP
    } state_t;

    // RW always writes; RS/RC write only when the source operand is non-zero.
    function automatic logic writes_intended(input logic [1:0] op, input logic src_zero);
        return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && !src_zero);
    endfunction

endpackage

// File: rtl/csr_rmw_seq_if.sv
// Bundle of request, CSR-file, logic-unit and response signals of the sequencer.
// slave = sequencer side, master = surrounding pipeline/CSR file/logic unit side.
interface csr_rmw_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      req_op_i;
    logic [11:0]     req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            req_src_zero_i;
    logic            flush_i;
    logic [11:0]     csr_raddr_o;
    logic [XLEN-1:0] csr_rdata_i;
    logic            csr_we_o;
    logic [11:0]     csr_waddr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic [XLEN-1:0] lu_op1_o;
    logic [XLEN-1:0] lu_op2_o;
    logic [7:0]      lu_sel_o;
    logic [XLEN-1:0] lu_result_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, flush_i,
        input  csr_rdata_i, lu_result_i, rsp_ready_i,
        output req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output lu_op1_o, lu_op2_o, lu_sel_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, flush_i,
        output csr_rdata_i, lu_result_i, rsp_ready_i,
        input  req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  lu_op1_o, lu_op2_o, lu_sel_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/csr_rmw_seq.sv
// CSR read-modify-write sequencer: READ -> EXEC (shared logic unit) -> WRITE -> RESP.
// Optional macro CSR_RMW_RO_CHECK_EN rejects writes to the read-only space addr[11:10]=2'b11.
module csr_rmw_seq
    import csr_rmw_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    csr_rmw_seq_if.slave  bus
);

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            src_zero_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;
    logic            err_q;
    logic            ro_violation;
    logic            abort_op;

`ifdef CSR_RMW_RO_CHECK_EN
    assign ro_violation = (addr_q[11:10] == 2'b11) && writes_intended(op_q, src_zero_q);
`else
    assign ro_violation = 1'b0;
`endif

    assign abort_op = (op_q == OP_RSVD) || ro_violation;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.req_valid_i) state_d = ST_READ;
            ST_READ: begin
                if (bus.flush_i)   state_d = ST_IDLE;
                else if (abort_op) state_d = ST_RESP;
                else               state_d = ST_EXEC;
            end
            ST_EXEC:  state_d = bus.flush_i ? ST_IDLE : ST_WRITE;
            // Once the write is committed a flush can no longer cancel the response.
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= OP_RW;
            addr_q     <= '0;
            wdata_q    <= '0;
            src_zero_q <= 1'b0;
            old_q      <= '0;
            new_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q       <= bus.req_op_i;
                        addr_q     <= bus.req_addr_i;
                        wdata_q    <= bus.req_wdata_i;
                        src_zero_q <= bus.req_src_zero_i;
                        err_q      <= 1'b0;
                    end
                end
                ST_READ: begin
                    old_q <= bus.csr_rdata_i;
                    if (abort_op) err_q <= 1'b1;
                end
                ST_EXEC: new_q <= bus.lu_result_i;
                default: ;
            endcase
        end
    end

    assign bus.csr_raddr_o = addr_q;
    assign bus.csr_waddr_o = addr_q;
    assign bus.csr_wdata_o = new_q;
    assign bus.rsp_rdata_o = old_q;

    always_comb begin
        bus.req_ready_o = 1'b0;
        bus.csr_we_o    = 1'b0;
        bus.lu_sel_o    = 8'h00;
        bus.lu_op1_o    = '0;
        bus.lu_op2_o    = '0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_err_o   = 1'b0;
        case (state_q)
            ST_IDLE: bus.req_ready_o = 1'b1;
            ST_EXEC: begin
                bus.lu_op2_o = wdata_q;
                case (op_q)
                    // RW passes wdata through the OR path with a zero first operand.
                    OP_RW: bus.lu_sel_o = SEL_OR;
                    OP_RS: begin
                        bus.lu_sel_o = SEL_SET;
                        bus.lu_op1_o = old_q;
                    end
                    OP_RC: begin
                        bus.lu_sel_o = SEL_CLR;
                        bus.lu_op1_o = old_q;
                    end
                    default: bus.lu_op2_o = '0;
                endcase
            end
            ST_WRITE: bus.csr_we_o = writes_intended(op_q, src_zero_q);
            ST_RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_rmw_seq.sv
// Randomized self-checking bench for csr_rmw_seq against a transaction-level CSR model.
module tb_csr_rmw_seq;

`ifdef CSR_RMW_RO_CHECK_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    csr_rmw_seq_if #(.XLEN(32)) bus ();

    csr_rmw_seq #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External CSR file and logic unit seen by the DUT.
    logic [31:0] csr_file [0:4095];
    logic [31:0] ref_mem  [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    assign bus.csr_rdata_i = csr_file[bus.csr_raddr_o];
    assign bus.lu_result_i = (bus.lu_sel_o == 8'h02) ? (bus.lu_op1_o | bus.lu_op2_o) :
                             (bus.lu_sel_o == 8'h40) ? (bus.lu_op1_o | bus.lu_op2_o) :
                             (bus.lu_sel_o == 8'h80) ? (bus.lu_op1_o & ~bus.lu_op2_o) : 32'h0;

    always @(posedge clk) begin
        if (bus.csr_we_o)  csr_file[bus.csr_waddr_o] <= bus.csr_wdata_o;
        else if (pre_en)   csr_file[pre_addr] <= pre_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_csr(input logic [11:0] addr, input logic [31:0] val);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = val;
        ref_mem[addr] = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic sz);
        check_val("req_ready", {31'b0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = op;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_src_zero_i = sz;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic run_txn(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic sz, input int hold);
        logic [31:0] old_v, new_v, wd, r0, exp_sel;
        logic [11:0] wa;
        logic        exp_wr, exp_err, e0;
        int          wr_cnt, wk, rsp_k;
        old_v   = ref_mem[addr];
        exp_err = (op == 2'b11) || (RO_EN && (addr[11:10] == 2'b11) && (op == 2'b00 || !sz));
        case (op)
            2'b00:   new_v = wdata;
            2'b01:   new_v = old_v | wdata;
            2'b10:   new_v = old_v & ~wdata;
            default: new_v = old_v;
        endcase
        exp_sel = (op == 2'b00) ? 32'h02 : (op == 2'b01) ? 32'h40 : 32'h80;
        exp_wr  = !exp_err && (op == 2'b00 || !sz);
        if (exp_wr) ref_mem[addr] = new_v;
        $display("TXN op=%0d addr=%h wdata=%h sz=%0b old=%h new=%h wr=%0b err=%0b hold=%0d",
                 op, addr, wdata, sz, old_v, new_v, exp_wr, exp_err, hold);
        issue(op, addr, wdata, sz);
        wr_cnt = 0; wk = 0; rsp_k = 0; wa = '0; wd = '0; r0 = '0; e0 = 1'b0;
        for (int k = 1; k <= 12 && rsp_k == 0; k++) begin
            @(negedge clk);
            if (bus.csr_we_o) begin
                wr_cnt++; wk = k; wa = bus.csr_waddr_o; wd = bus.csr_wdata_o;
            end
            if (k == 2 && !exp_err) check_val("lu_sel", {24'b0, bus.lu_sel_o}, exp_sel);
            if (bus.rsp_valid_o) rsp_k = k;
        end
        check_val("rsp_cycle", rsp_k, exp_err ? 32'd2 : 32'd4);
        if (rsp_k != 0) begin
            r0 = bus.rsp_rdata_o;
            e0 = bus.rsp_err_o;
            check_val("rsp_rdata", r0, old_v);
            check_val("rsp_err", {31'b0, e0}, {31'b0, exp_err});
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (bus.csr_we_o) wr_cnt++;
                check_val("hold_valid", {31'b0, bus.rsp_valid_o}, 32'd1);
                check_val("hold_rdata", bus.rsp_rdata_o, r0);
                check_val("hold_err", {31'b0, bus.rsp_err_o}, {31'b0, e0});
            end
            bus.rsp_ready_i = 1'b1;
            @(negedge clk);
            bus.rsp_ready_i = 1'b0;
            check_val("post_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
        end
        check_val("wr_count", wr_cnt, exp_wr ? 32'd1 : 32'd0);
        if (exp_wr && wr_cnt == 1) begin
            check_val("wr_cycle", wk, 32'd3);
            check_val("wr_addr", {20'b0, wa}, {20'b0, addr});
            check_val("wr_data", wd, new_v);
        end
    endtask

    task automatic run_flush(input int fk, input logic [11:0] addr);
        int wr_cnt, rsp_cnt;
        $display("TXN flush_at=%0d addr=%h", fk, addr);
        issue(2'b00, addr, $urandom, 1'b0);
        wr_cnt = 0; rsp_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.csr_we_o) wr_cnt++;
            if (bus.rsp_valid_o) rsp_cnt++;
            if (k == fk) bus.flush_i = 1'b1;
            if (k == fk + 1) begin
                bus.flush_i = 1'b0;
                check_val("flush_ready", {31'b0, bus.req_ready_o}, 32'd1);
            end
        end
        check_val("flush_wr", wr_cnt, 32'd0);
        check_val("flush_rsp", rsp_cnt, 32'd0);
    endtask

    task automatic run_reset_in_write(input logic [11:0] addr);
        int rsp_cnt;
        $display("TXN reset_in_write addr=%h", addr);
        issue(2'b00, addr, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_pre_we", {31'b0, bus.csr_we_o}, 32'd1);
        #2 rst = 1'b1;
        #1 check_val("rst_we_drop", {31'b0, bus.csr_we_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) rsp_cnt++;
        end
        check_val("rst_rsp", rsp_cnt, 32'd0);
        check_val("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    endtask

    initial begin
        logic [11:0] addrs [6];
        addrs = '{12'h300, 12'h305, 12'h341, 12'hC00, 12'hC01, 12'h7C0};
        n_checks = 0;
        n_fail   = 0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus.req_valid_i = 1'b0; bus.req_op_i = 2'b00; bus.req_addr_i = '0;
        bus.req_wdata_i = '0; bus.req_src_zero_i = 1'b0; bus.flush_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
        check_val("rst_we", {31'b0, bus.csr_we_o}, 32'd0);
        check_val("rst_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
        check_val("rst_err", {31'b0, bus.rsp_err_o}, 32'd0);
        check_val("rst_sel", {24'b0, bus.lu_sel_o}, 32'd0);
        check_val("rst_rdata", bus.rsp_rdata_o, 32'd0);

        foreach (addrs[i]) set_csr(addrs[i], $urandom);

        set_csr(12'h300, 32'h0000_0008);
        run_txn(2'b01, 12'h300, 32'h0000_0080, 1'b0, 0);
        set_csr(12'h305, 32'hFFFF_FFFF);
        run_txn(2'b10, 12'h305, 32'h0000_00F0, 1'b0, 0);
        set_csr(12'h341, 32'h0000_1234);
        run_txn(2'b01, 12'h341, 32'h0000_0000, 1'b1, 0);
        run_txn(2'b11, 12'h341, 32'h5555_AAAA, 1'b0, 0);
        run_txn(2'b00, 12'h305, 32'h0F0F_0F0F, 1'b0, 3);
        run_flush(2, 12'h305);
        run_flush(1, 12'h300);
        run_reset_in_write(12'h300);
        run_txn(2'b00, 12'hC00, 32'hA5A5_5A5A, 1'b0, 1);

        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 5)], $urandom,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        foreach (addrs[i]) check_val("final_mem", csr_file[addrs[i]], ref_mem[addrs[i]]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
